// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared types and defaults for the fetch responder.
// Exports the FSM state enum and default geometry / error word.
package pc_fetch_pkg;

   localparam int DEF_ADDR_W = 4;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_DEPTH  = 12;

   // Wide enough for any DATA_W up to 32; truncated at use.
   localparam logic [31:0] DEF_ERR_DATA = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/pc_fetch_store.sv
// pc_fetch_store: DEPTH x DATA_W flop store, one write port, one
// registered read port (read-before-write), out-of-range flagging.
// Ports: clk, rst_n, ena | wr_en/wr_addr/wr_data | rd_en/rd_addr
//        -> rd_data/rd_err (registered, updated only on rd_en).
module pc_fetch_store
   import pc_fetch_pkg::*;
#(
   parameter int                ADDR_W   = DEF_ADDR_W,
   parameter int                DATA_W   = DEF_DATA_W,
   parameter int                DEPTH    = DEF_DEPTH,
   parameter logic [DATA_W-1:0] ERR_DATA = '1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_err
);

   localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_word;
   logic              wr_ok;
   logic              rd_oob;

   assign wr_ok  = ena && wr_en && ({1'b0, wr_addr} < LIMIT);
   assign rd_oob = ({1'b0, rd_addr} >= LIMIT);

   always_comb begin
      rd_word = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (rd_addr == ADDR_W'(i)) rd_word = mem[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_ok) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_addr == ADDR_W'(i)) mem[i] <= wr_data;
         end
      end
   end

   // Sampled from the pre-edge array, so a same-edge write is not seen.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data <= '0;
         rd_err  <= 1'b0;
      end else if (ena && rd_en) begin
         rd_data <= rd_oob ? ERR_DATA : rd_word;
         rd_err  <= rd_oob;
      end
   end

endmodule

// File: rtl/pc_fetch_responder.sv
// pc_fetch_responder: accepts a PC address (pc_valid/pc_ready), reads
// the store, returns the word (instr_valid/instr_ready); host preload
// via wr_*; fetch_count counts completed fetches; ena=0 freezes all.
module pc_fetch_responder
   import pc_fetch_pkg::*;
#(
   parameter int                ADDR_W   = DEF_ADDR_W,
   parameter int                DATA_W   = DEF_DATA_W,
   parameter int                DEPTH    = DEF_DEPTH,
   parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(DEF_ERR_DATA)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              pc_valid,
   input  logic [ADDR_W-1:0] pc_addr,
   output logic              pc_ready,
   output logic              instr_valid,
   output logic [DATA_W-1:0] instr_data,
   output logic              instr_err,
   input  logic              instr_ready,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [7:0]        fetch_count
);

   state_t            state_q, state_d;
   logic              rdy_q, rdy_d;
   logic              vld_q, vld_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              rd_en;
   logic [DATA_W-1:0] rd_data;
   logic              rd_err;

   pc_fetch_store #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .ERR_DATA (ERR_DATA)
   ) u_store (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (rd_en),
      .rd_addr (addr_q),
      .rd_data (rd_data),
      .rd_err  (rd_err)
   );

   // RESP has two phases: first cycle latches the store read into the
   // output register, then the word is presented and held.
   always_comb begin
      state_d = state_q;
      rdy_d   = rdy_q;
      vld_d   = vld_q;
      err_d   = err_q;
      addr_d  = addr_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      rd_en   = 1'b0;
      unique case (state_q)
         IDLE: begin
            rdy_d = 1'b1;
            if (pc_valid && rdy_q) begin
               addr_d  = pc_addr;
               rdy_d   = 1'b0;
               state_d = READ;
            end
         end
         READ: begin
            rd_en   = 1'b1;
            state_d = RESP;
         end
         RESP: begin
            if (!vld_q) begin
               vld_d  = 1'b1;
               data_d = rd_data;
               err_d  = rd_err;
            end else if (instr_ready) begin
               vld_d   = 1'b0;
               cnt_d   = cnt_q + 8'd1;
               rdy_d   = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rdy_q   <= 1'b0;
         vld_q   <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
      end else if (ena) begin
         state_q <= state_d;
         rdy_q   <= rdy_d;
         vld_q   <= vld_d;
         err_q   <= err_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
      end
   end

   assign pc_ready    = rdy_q && ena;
   assign instr_valid = vld_q;
   assign instr_data  = data_q;
   assign instr_err   = err_q;
   assign fetch_count = cnt_q;

endmodule
